// File: rtl/apb4_master_bridge.sv
// APB4 master bridge: turns a valid/ready command into one APB4 transfer and
// returns a single-cycle registered response, with an optional wait-state timeout.
module apb4_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    // command side
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    // response side
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    // APB4 bus
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic [DATA_WIDTH-1:0]   PRDATA
);

    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned WAIT_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned WAIT_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    cmd_ready_d;
    logic                    psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;
    logic [STRB_W-1:0]       pstrb_d;
    logic [2:0]              pprot_d;
    logic                    rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;

    // State and all outputs are registered; cmd_ready rises on the first edge after reset release.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            cmd_ready   <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PPROT       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cmd_ready   <= cmd_ready_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            PSTRB       <= pstrb_d;
            PPROT       <= pprot_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_slverr  <= rsp_slverr_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    // Next state and next registered outputs; bus fields hold unless a command is taken.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        cmd_ready_d   = cmd_ready;
        psel_d        = PSEL;
        penable_d     = PENABLE;
        pwrite_d      = PWRITE;
        paddr_d       = PADDR;
        pwdata_d      = PWDATA;
        pstrb_d       = PSTRB;
        pprot_d       = PPROT;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_slverr_d  = 1'b0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    state_d     = ST_SETUP;
                    wait_d      = '0;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                    pstrb_d     = cmd_write ? cmd_strb  : '0;
                    pprot_d     = cmd_prot;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d      = ST_IDLE;
                    cmd_ready_d  = 1'b1;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = PWRITE ? '0 : PRDATA;
                    rsp_slverr_d = PSLVERR;
                end else if (TIMEOUT_EN && (wait_q == WAIT_W'(WAIT_LAST))) begin
                    state_d       = ST_IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed bench for apb4_master_bridge (TIMEOUT_CYCLES=4); the APB slave side
// is driven step by step from the stimulus sequence.
module tb_apb4_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_slverr, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] PRDATA;

    int total = 0;
    int bad   = 0;

    apb4_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .PRDATA      (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic [2:0] prot);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = strb;
        cmd_prot  = prot;
    endtask

    // OR of every output bit; 0 means every output is at its reset value.
    function automatic logic any_out();
        return |{cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
                 PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT};
    endfunction

    initial begin
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;

        // reset
        tick(); tick();
        chk("reset_outputs_zero", 32'(any_out()), 32'd0);
        PRESETn = 1'b1;
        tick();
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // zero-wait write
        PREADY = 1'b1;
        set_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0);
        tick();
        cmd_valid = 1'b0;
        chk("wr_setup_psel", 32'({PSEL, PENABLE, cmd_ready}), 32'b100);
        chk("wr_paddr", PADDR, 32'h10);
        chk("wr_pwdata", PWDATA, 32'hDEADBEEF);
        chk("wr_pstrb_pwrite", 32'({PSTRB, PWRITE}), 32'h1F);
        tick();
        chk("wr_access", 32'({PSEL, PENABLE, rsp_valid}), 32'b110);
        tick();
        chk("wr_rsp", 32'({rsp_valid, rsp_slverr, rsp_timeout, cmd_ready, PSEL, PENABLE}), 32'b100100);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("idle_paddr_held", PADDR, 32'h10);
        tick();
        chk("wr_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // read with 2 wait states; strobes forced to 0
        PREADY = 1'b0;
        set_cmd(1'b0, 32'h24, 32'hAAAA5555, 4'hF, 3'd2);
        tick();
        cmd_valid = 1'b0;
        chk("rd_setup_pstrb_pwdata", 32'(PSTRB) | PWDATA, 32'd0);
        chk("rd_pwrite_pprot", 32'({PWRITE, PPROT}), 32'b0010);
        tick();
        PRDATA = 32'hBADBAD00;
        chk("rd_access1", 32'({PSEL, PENABLE}), 32'b11);
        tick();
        chk("rd_access2", 32'({PSEL, PENABLE, rsp_valid}), 32'b110);
        tick();
        chk("rd_access3", 32'({PSEL, PENABLE, rsp_valid, PSTRB}), 32'b110_0000);
        PREADY = 1'b1; PRDATA = 32'h12345678;
        tick();
        chk("rd_rsp_valid", 32'({rsp_valid, rsp_slverr, rsp_timeout}), 32'b100);
        chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        PREADY = 1'b0; PRDATA = '0;

        // PSLVERR pulse while PREADY=0 is ignored
        set_cmd(1'b1, 32'h3C, 32'h1, 4'h1, 3'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        PSLVERR = 1'b1;
        tick();
        PSLVERR = 1'b0; PREADY = 1'b1;
        tick();
        chk("err_ignored_rsp", 32'({rsp_valid, rsp_slverr}), 32'b10);

        // slave error on completion
        PSLVERR = 1'b1;
        set_cmd(1'b1, 32'h3C, 32'h2, 4'h3, 3'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("slverr_rsp", 32'({rsp_valid, rsp_slverr, rsp_timeout}), 32'b110);
        PSLVERR = 1'b0; PREADY = 1'b0;

        // timeout after exactly 4 ACCESS cycles
        PRDATA = 32'h5A5A5A5A;
        set_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'd1);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_access%0d", i), 32'({PSEL, PENABLE, rsp_valid}), 32'b110);
        end
        tick();
        chk("to_rsp", 32'({rsp_valid, rsp_slverr, rsp_timeout, PSEL, PENABLE, cmd_ready}), 32'b111001);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        PRDATA = 32'hCAFEF00D;

        // three back-to-back commands with cmd_valid held high
        PREADY = 1'b1;
        set_cmd(1'b1, 32'h100, 32'h11, 4'hF, 3'd0);
        tick();
        chk("b2b_a_setup", PADDR, 32'h100);
        set_cmd(1'b0, 32'h104, 32'h22, 4'hF, 3'd0);
        tick();
        chk("b2b_a_access_busy", 32'({cmd_ready, PENABLE, PADDR == 32'h100}), 32'b011);
        tick();
        chk("b2b_a_rsp", 32'({rsp_valid, PSEL, cmd_ready}), 32'b101);
        chk("b2b_a_rdata", rsp_rdata, 32'd0);
        tick();
        chk("b2b_b_setup", 32'({PSEL, PENABLE, rsp_valid, PWRITE}), 32'b1000);
        chk("b2b_b_paddr", PADDR, 32'h104);
        set_cmd(1'b1, 32'h108, 32'h33, 4'h5, 3'd7);
        tick();
        tick();
        chk("b2b_b_rsp", 32'({rsp_valid, PSEL}), 32'b10);
        chk("b2b_b_rdata", rsp_rdata, 32'hCAFEF00D);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_c_setup", PADDR, 32'h108);
        chk("b2b_c_fields", 32'({PSTRB, PPROT, PWRITE}), 32'b0101_111_1);
        tick();
        tick();
        chk("b2b_c_rsp", 32'({rsp_valid, rsp_slverr, PSEL}), 32'b100);
        tick();
        chk("b2b_idle", 32'({rsp_valid, PSEL, cmd_ready}), 32'b001);

        // reset during a wait state
        PREADY = 1'b0;
        set_cmd(1'b1, 32'h200, 32'h44, 4'hF, 3'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid_in_access", 32'({PSEL, PENABLE}), 32'b11);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_mid_async_zero", 32'(any_out()), 32'd0);
        PREADY = 1'b1;
        tick();
        chk("rst_mid_no_rsp", 32'(any_out()), 32'd0);
        PRESETn = 1'b1;
        tick();
        chk("rst_mid_ready", 32'({cmd_ready, rsp_valid}), 32'b10);
        set_cmd(1'b1, 32'h300, 32'h55, 4'hF, 3'd0);
        tick();
        cmd_valid = 1'b0;
        chk("post_rst_setup", PADDR, 32'h300);
        tick();
        tick();
        chk("post_rst_rsp", 32'({rsp_valid, rsp_slverr, rsp_timeout}), 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
